// File: rtl/deser_pkg.sv
// Shared types and constants for the serial-to-parallel frame controller.
package deser_pkg;

    localparam int unsigned DEF_N    = 8;
    localparam int unsigned DEF_WCW  = 8;
    localparam int unsigned DEF_DIVW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Bit counter width; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/deser_shift.sv
// N-bit MSB-first shift register with shift enable and synchronous clear.
module deser_shift
    import deser_pkg::*;
#(
    parameter int unsigned N = DEF_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         shift_en,
    input  logic         ser_in,
    output logic [N-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {q[N-2:0], ser_in};
        end
    end

endmodule

// File: rtl/deser_frame_ctrl.sv
// Frame sequencer: bit-rate divider, bit/word counters and a valid/ready
// output register around the deser_shift datapath.
module deser_frame_ctrl
    import deser_pkg::*;
#(
    parameter int unsigned N    = DEF_N,
    parameter int unsigned WCW  = DEF_WCW,
    parameter int unsigned DIVW = DEF_DIVW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [WCW-1:0]  num_words,
    input  logic [DIVW-1:0] clk_div,
    input  logic            ser_in,
    output logic            bit_tick,
    output logic [N-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            done,
    output logic            overrun
);

    localparam int unsigned BCW = cnt_width(N);

    state_t          state;
    logic [DIVW-1:0] div_cnt;
    logic [DIVW-1:0] div_inc;
    logic [DIVW-1:0] clk_div_r;
    logic [BCW-1:0]  bit_cnt;
    logic [WCW-1:0]  word_cnt;
    logic [WCW-1:0]  word_inc;
    logic [WCW-1:0]  num_words_r;
    logic [N-1:0]    shift_q;
    logic [N-1:0]    word_next;
    logic            accept;
    logic            kill;
    logic            handshake;
    logic            word_done;
    logic            last_word;

    always_comb begin
        accept    = (state == IDLE) && start && (num_words != '0);
        kill      = (state != IDLE) && abort;
        handshake = out_valid && out_ready;
        div_inc   = div_cnt + 1'b1;
        word_inc  = word_cnt + 1'b1;
        word_done = bit_tick && (bit_cnt == BCW'(N - 1));
        last_word = word_done && (word_inc == num_words_r);
        word_next = {shift_q[N-2:0], ser_in};
    end

    assign busy = (state != IDLE);

    deser_shift #(.N(N)) u_shift (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept || kill),
        .shift_en (bit_tick),
        .ser_in   (ser_in),
        .q        (shift_q)
    );

    // bit_tick is registered: it is precomputed from the divider value the
    // next cycle will hold, so it is high exactly when div_cnt == clk_div_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            div_cnt     <= '0;
            clk_div_r   <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            num_words_r <= '0;
            bit_tick    <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (kill) begin
                state     <= IDLE;
                div_cnt   <= '0;
                bit_cnt   <= '0;
                word_cnt  <= '0;
                bit_tick  <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        bit_tick <= 1'b0;
                        if (accept) begin
                            num_words_r <= num_words;
                            clk_div_r   <= clk_div;
                            overrun     <= 1'b0;
                            div_cnt     <= '0;
                            bit_cnt     <= '0;
                            word_cnt    <= '0;
                            bit_tick    <= (clk_div == '0);
                            state       <= RUN;
                        end else if (start) begin
                            done <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (handshake) begin
                            out_valid <= 1'b0;
                        end
                        if (bit_tick) begin
                            div_cnt  <= '0;
                            bit_tick <= (clk_div_r == '0);
                            if (word_done) begin
                                bit_cnt   <= '0;
                                word_cnt  <= word_inc;
                                out_data  <= word_next;
                                out_valid <= 1'b1;
                                if (out_valid && !out_ready) begin
                                    overrun <= 1'b1;
                                end
                                if (last_word) begin
                                    bit_tick <= 1'b0;
                                    state    <= FLUSH;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            div_cnt  <= div_inc;
                            bit_tick <= (div_inc == clk_div_r);
                        end
                    end
                    FLUSH: begin
                        bit_tick <= 1'b0;
                        if (handshake) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            div_cnt   <= '0;
                            bit_cnt   <= '0;
                            word_cnt  <= '0;
                            state     <= IDLE;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        bit_tick <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_deser_frame_ctrl.sv
// Directed self-checking bench for deser_frame_ctrl (N=8, WCW=8, DIVW=8).
module tb_deser_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] num_words;
    logic [7:0] clk_div;
    logic       ser_in;
    logic       bit_tick;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic       overrun;

    int          checks   = 0;
    int          failures = 0;
    int          cyc;
    int          div_g;
    int          tick_last;
    int          done_cyc;
    int          nbits;
    logic [31:0] stream;

    deser_frame_ctrl #(.N(8), .WCW(8), .DIVW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .num_words (num_words),
        .clk_div   (clk_div),
        .ser_in    (ser_in),
        .bit_tick  (bit_tick),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s @cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Cycle k is the interval after the k-th edge following the start edge.
    // The bit sampled at a tick in cycle c is stream bit (c-1)/(div+1), MSB first.
    task automatic step();
        int idx;
        logic exp_tick;
        @(posedge clk);
        #1;
        cyc++;
        ser_in = 1'b0;
        if (cyc >= 1) begin
            idx = (cyc - 1) / (div_g + 1);
            if (idx < nbits) ser_in = stream[nbits - 1 - idx];
        end
        exp_tick = (cyc >= 1) && (cyc <= tick_last) && ((cyc % (div_g + 1)) == 0);
        check("bit_tick", bit_tick, exp_tick);
        check("done", done, cyc == done_cyc);
    endtask

    task automatic begin_frame(input int div, input int nw, input logic [31:0] s,
                               input int nb, input int tl, input int dc);
        clk_div   = div[7:0];
        num_words = nw[7:0];
        stream    = s;
        nbits     = nb;
        div_g     = div;
        tick_last = tl;
        done_cyc  = dc;
        start     = 1'b1;
        cyc       = 0;
        step();
        start     = 1'b0;
    endtask

    // Two-word frame, clk_div=3: ticks at 4,8..64, words at 33 and 65, done at 66.
    task automatic run_std(input bit busy_start);
        begin_frame(3, 2, 32'h0000_A53C, 16, 64, 66);
        out_ready = 1'b1;
        while (cyc < 67) begin
            if (cyc == 1)  check("busy_run", busy, 1'b1);
            if (cyc == 32) check("valid_pre", out_valid, 1'b0);
            if (cyc == 33) begin
                check("w0_valid", out_valid, 1'b1);
                check("w0_data", out_data, 8'hA5);
            end
            if (cyc == 34) check("w0_accepted", out_valid, 1'b0);
            if (cyc == 65) begin
                check("w1_valid", out_valid, 1'b1);
                check("w1_data", out_data, 8'h3C);
                check("busy_flush", busy, 1'b1);
            end
            if (cyc == 66) begin
                check("busy_end", busy, 1'b0);
                check("valid_end", out_valid, 1'b0);
                check("overrun_clean", overrun, 1'b0);
            end
            if (busy_start && cyc == 10) begin
                start     = 1'b1;
                num_words = 8'd5;
                clk_div   = 8'd0;
            end
            if (busy_start && cyc == 11) start = 1'b0;
            step();
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; num_words = '0; clk_div = '0;
        ser_in = 1'b0; out_ready = 1'b0;
        cyc = -100; div_g = 0; tick_last = 0; done_cyc = -1; nbits = 0; stream = '0;
        repeat (3) step();
        check("rst_busy", busy, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 8'h00);
        check("rst_overrun", overrun, 1'b0);
        reset = 1'b0;
        step();

        run_std(1'b0);

        // Consumer stalls until cycle 70: second word overwrites and sets overrun.
        begin_frame(3, 2, 32'h0000_A53C, 16, 64, 71);
        out_ready = 1'b0;
        while (cyc < 72) begin
            if (cyc == 33) check("ov_w0_data", out_data, 8'hA5);
            if (cyc == 64) begin
                check("ov_hold_data", out_data, 8'hA5);
                check("ov_pre", overrun, 1'b0);
            end
            if (cyc == 65) begin
                check("ov_w1_data", out_data, 8'h3C);
                check("ov_valid", out_valid, 1'b1);
                check("ov_set", overrun, 1'b1);
            end
            if (cyc == 70) begin
                check("ov_busy_wait", busy, 1'b1);
                out_ready = 1'b1;
            end
            if (cyc == 71) begin
                check("ov_busy_end", busy, 1'b0);
                check("ov_sticky", overrun, 1'b1);
            end
            step();
        end

        // num_words=0: immediate done, overrun retained, never busy.
        begin_frame(3, 0, 32'h0, 0, 0, 1);
        check("nw0_busy", busy, 1'b0);
        check("nw0_overrun_kept", overrun, 1'b1);
        step();
        check("nw0_busy2", busy, 1'b0);

        // clk_div=0, one word of all ones: ticks 1..8, 0xFF at 9, done at 10.
        begin_frame(0, 1, 32'h0000_00FF, 8, 8, 10);
        out_ready = 1'b1;
        check("fast_overrun_clr", overrun, 1'b0);
        while (cyc < 11) begin
            if (cyc == 8) check("fast_valid_pre", out_valid, 1'b0);
            if (cyc == 9) begin
                check("fast_valid", out_valid, 1'b1);
                check("fast_data", out_data, 8'hFF);
            end
            if (cyc == 10) check("fast_busy_end", busy, 1'b0);
            step();
        end

        // Abort at cycle 20, then a clean restart.
        begin_frame(3, 2, 32'h0000_A53C, 16, 20, -1);
        out_ready = 1'b1;
        while (cyc < 30) begin
            if (cyc == 20) abort = 1'b1;
            if (cyc == 21) begin
                abort = 1'b0;
                check("abort_busy", busy, 1'b0);
                check("abort_valid", out_valid, 1'b0);
            end
            step();
        end
        run_std(1'b0);

        // Start while busy (num_words=5, clk_div=0) must not alter the frame.
        run_std(1'b1);
        num_words = 8'd2;
        clk_div   = 8'd3;
        while (cyc < 75) begin
            check("no_second_frame", busy, 1'b0);
            step();
        end

        // Reset at cycle 30 while FLUSH holds a stalled word with overrun set.
        begin_frame(0, 3, 32'h0012_3456, 24, 24, -1);
        out_ready = 1'b0;
        while (cyc < 33) begin
            if (cyc == 9)  check("rs_w0_data", out_data, 8'h12);
            if (cyc == 17) begin
                check("rs_w1_data", out_data, 8'h34);
                check("rs_overrun", overrun, 1'b1);
            end
            if (cyc == 25) begin
                check("rs_w2_data", out_data, 8'h56);
                check("rs_busy", busy, 1'b1);
            end
            if (cyc == 30) reset = 1'b1;
            if (cyc == 31) begin
                reset = 1'b0;
                check("rs_busy_clr", busy, 1'b0);
                check("rs_valid_clr", out_valid, 1'b0);
                check("rs_data_clr", out_data, 8'h00);
                check("rs_overrun_clr", overrun, 1'b0);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
